// File: rtl/axi_slave_port.sv
// Crossbar slave-side port: round-robin arbitration of per-master AR/AW/W FIFOs onto one
// single-outstanding AXI master, with R/B responses steered back by the master field of the ID.
module axi_slave_port #(
    parameter int N_MST = 4
) (
    input  logic                  AXI_CLK_i,
    input  logic                  AXI_RST_i,
    input  logic [N_MST-1:0]      ar_req_i,
    input  logic [N_MST*49-1:0]   ar_data_i,
    output logic [N_MST-1:0]      ar_pop_o,
    input  logic [N_MST-1:0]      aw_req_i,
    input  logic [N_MST*49-1:0]   aw_data_i,
    output logic [N_MST-1:0]      aw_pop_o,
    input  logic [N_MST-1:0]      w_valid_i,
    input  logic [N_MST*37-1:0]   w_data_i,
    output logic [N_MST-1:0]      w_pop_o,
    input  logic [N_MST-1:0]      r_full_i,
    input  logic [N_MST-1:0]      b_full_i,
    output logic [N_MST-1:0]      r_push_o,
    output logic [42:0]           r_data_o,
    output logic [N_MST-1:0]      b_push_o,
    output logic [9:0]            b_data_o,
    output logic                  wlast_err_o,
    output logic [7:0]            ARID_o,
    output logic [31:0]           ARADDR_o,
    output logic [3:0]            ARLEN_o,
    output logic [2:0]            ARSIZE_o,
    output logic [1:0]            ARBURST_o,
    output logic                  ARVALID_o,
    input  logic                  ARREADY_i,
    input  logic [7:0]            RID_i,
    input  logic [31:0]           RDATA_i,
    input  logic [1:0]            RRESP_i,
    input  logic                  RLAST_i,
    input  logic                  RVALID_i,
    output logic                  RREADY_o,
    output logic [7:0]            AWID_o,
    output logic [31:0]           AWADDR_o,
    output logic [3:0]            AWLEN_o,
    output logic [2:0]            AWSIZE_o,
    output logic [1:0]            AWBURST_o,
    output logic                  AWVALID_o,
    input  logic                  AWREADY_i,
    output logic [31:0]           WDATA_o,
    output logic [3:0]            WSTRB_o,
    output logic                  WLAST_o,
    output logic                  WVALID_o,
    input  logic                  WREADY_i,
    input  logic [7:0]            BID_i,
    input  logic [1:0]            BRESP_i,
    input  logic                  BVALID_i,
    output logic                  BREADY_o
);

    localparam int PW = (N_MST > 1) ? $clog2(N_MST) : 1;

    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;

    // Round-robin search starting one past the previous winner
    function automatic logic [PW-1:0] rr_pick(input logic [N_MST-1:0] req,
                                              input logic [PW-1:0]    last);
        logic [PW-1:0] pick;
        logic          found;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= N_MST; i++) begin
            idx = (int'(last) + i) % N_MST;
            if (!found && req[idx]) begin
                pick  = PW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    rd_state_t        rd_state_r, rd_state_s;
    wr_state_t        wr_state_r, wr_state_s;
    logic [PW-1:0]    ar_last_r, aw_last_r, ar_grant_s, aw_grant_s, wsel_r;
    logic [N_MST-1:0] ar_pop_s, aw_pop_s, w_pop_s, r_push_s, b_push_s, r_sel_s, b_sel_s;
    logic [48:0]      ar_sel_s, aw_sel_s;
    logic [36:0]      w_sel_s;
    logic             rready_s, bready_s, wvalid_s, wlast_s, w_beat_s;
    logic             arvalid_r, awvalid_r, wlast_err_r;
    logic [7:0]       arid_r, awid_r;
    logic [31:0]      araddr_r, awaddr_r;
    logic [3:0]       arlen_r, awlen_r, wcnt_r;
    logic [2:0]       arsize_r, awsize_r;
    logic [1:0]       arburst_r, awburst_r;

    // Read FSM next state, AR grant and R routing
    always_comb begin
        rd_state_s = rd_state_r;
        ar_grant_s = rr_pick(ar_req_i, ar_last_r);
        ar_sel_s   = ar_data_i[int'(ar_grant_s)*49 +: 49];
        ar_pop_s   = '0;
        r_push_s   = '0;
        rready_s   = 1'b0;
        for (int m = 0; m < N_MST; m++) begin
            r_sel_s[m] = (RID_i[7:4] == 4'(m));
        end
        case (rd_state_r)
            RD_IDLE: begin
                if (|ar_req_i) begin
                    for (int m = 0; m < N_MST; m++) begin
                        ar_pop_s[m] = (ar_grant_s == PW'(m));
                    end
                    rd_state_s = RD_ADDR;
                end else begin
                    rd_state_s = RD_IDLE;
                end
            end
            RD_ADDR: begin
                if (ARREADY_i) begin
                    rd_state_s = RD_DATA;
                end else begin
                    rd_state_s = RD_ADDR;
                end
            end
            RD_DATA: begin
                // An ID naming no master is drained so the slave cannot stall the port
                rready_s = (r_sel_s == '0) ? 1'b1 : ~|(r_sel_s & r_full_i);
                r_push_s = r_sel_s & {N_MST{RVALID_i & rready_s}};
                if (RVALID_i && rready_s && RLAST_i) begin
                    rd_state_s = RD_IDLE;
                end else begin
                    rd_state_s = RD_DATA;
                end
            end
            default: begin
                rd_state_s = RD_IDLE;
            end
        endcase
    end

    // Read FSM state, AR pointer and registered AR channel
    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i) begin
            rd_state_r <= RD_IDLE;
            ar_last_r  <= PW'(N_MST - 1);
            arvalid_r  <= 1'b0;
            arid_r     <= 8'd0;
            araddr_r   <= 32'd0;
            arlen_r    <= 4'd0;
            arsize_r   <= 3'd0;
            arburst_r  <= 2'd0;
        end else begin
            rd_state_r <= rd_state_s;
            arvalid_r  <= (rd_state_s == RD_ADDR);
            if (|ar_pop_s) begin
                ar_last_r <= ar_grant_s;
                arid_r    <= {4'(ar_grant_s), ar_sel_s[44:41]};
                araddr_r  <= ar_sel_s[40:9];
                arlen_r   <= ar_sel_s[8:5];
                arsize_r  <= ar_sel_s[4:2];
                arburst_r <= ar_sel_s[1:0];
            end
        end
    end

    // Write FSM next state, AW grant, W forwarding and B routing
    always_comb begin
        wr_state_s = wr_state_r;
        aw_grant_s = rr_pick(aw_req_i, aw_last_r);
        aw_sel_s   = aw_data_i[int'(aw_grant_s)*49 +: 49];
        w_sel_s    = w_data_i[int'(wsel_r)*37 +: 37];
        aw_pop_s   = '0;
        w_pop_s    = '0;
        b_push_s   = '0;
        wvalid_s   = 1'b0;
        wlast_s    = 1'b0;
        w_beat_s   = 1'b0;
        bready_s   = 1'b0;
        for (int m = 0; m < N_MST; m++) begin
            b_sel_s[m] = (BID_i[7:4] == 4'(m));
        end
        case (wr_state_r)
            WR_IDLE: begin
                if (|aw_req_i) begin
                    for (int m = 0; m < N_MST; m++) begin
                        aw_pop_s[m] = (aw_grant_s == PW'(m));
                    end
                    wr_state_s = WR_ADDR;
                end else begin
                    wr_state_s = WR_IDLE;
                end
            end
            WR_ADDR: begin
                if (AWREADY_i) begin
                    wr_state_s = WR_DATA;
                end else begin
                    wr_state_s = WR_ADDR;
                end
            end
            WR_DATA: begin
                wvalid_s = w_valid_i[wsel_r];
                wlast_s  = (wcnt_r == awlen_r);
                w_beat_s = wvalid_s & WREADY_i;
                for (int m = 0; m < N_MST; m++) begin
                    w_pop_s[m] = (wsel_r == PW'(m)) & w_beat_s;
                end
                if (w_beat_s && wlast_s) begin
                    wr_state_s = WR_RESP;
                end else begin
                    wr_state_s = WR_DATA;
                end
            end
            WR_RESP: begin
                bready_s = (b_sel_s == '0) ? 1'b1 : ~|(b_sel_s & b_full_i);
                b_push_s = b_sel_s & {N_MST{BVALID_i & bready_s}};
                if (BVALID_i && bready_s) begin
                    wr_state_s = WR_IDLE;
                end else begin
                    wr_state_s = WR_RESP;
                end
            end
            default: begin
                wr_state_s = WR_IDLE;
            end
        endcase
    end

    // Write FSM state, AW pointer, AW channel, beat counter and sticky last-mismatch flag
    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i) begin
            wr_state_r  <= WR_IDLE;
            aw_last_r   <= PW'(N_MST - 1);
            awvalid_r   <= 1'b0;
            awid_r      <= 8'd0;
            awaddr_r    <= 32'd0;
            awlen_r     <= 4'd0;
            awsize_r    <= 3'd0;
            awburst_r   <= 2'd0;
            wsel_r      <= '0;
            wcnt_r      <= 4'd0;
            wlast_err_r <= 1'b0;
        end else begin
            wr_state_r <= wr_state_s;
            awvalid_r  <= (wr_state_s == WR_ADDR);
            if (|aw_pop_s) begin
                aw_last_r <= aw_grant_s;
                wsel_r    <= aw_grant_s;
                awid_r    <= {4'(aw_grant_s), aw_sel_s[44:41]};
                awaddr_r  <= aw_sel_s[40:9];
                awlen_r   <= aw_sel_s[8:5];
                awsize_r  <= aw_sel_s[4:2];
                awburst_r <= aw_sel_s[1:0];
                wcnt_r    <= 4'd0;
            end else if (w_beat_s) begin
                wcnt_r <= wcnt_r + 4'd1;
            end
            if (w_beat_s && (w_sel_s[0] != wlast_s)) begin
                wlast_err_r <= 1'b1;
            end
        end
    end

    assign ar_pop_o    = ar_pop_s;
    assign aw_pop_o    = aw_pop_s;
    assign w_pop_o     = w_pop_s;
    assign r_push_o    = r_push_s;
    assign b_push_o    = b_push_s;
    assign r_data_o    = {RID_i, RDATA_i, RRESP_i, RLAST_i};
    assign b_data_o    = {BID_i, BRESP_i};
    assign wlast_err_o = wlast_err_r;
    assign ARID_o      = arid_r;
    assign ARADDR_o    = araddr_r;
    assign ARLEN_o     = arlen_r;
    assign ARSIZE_o    = arsize_r;
    assign ARBURST_o   = arburst_r;
    assign ARVALID_o   = arvalid_r;
    assign RREADY_o    = rready_s;
    assign AWID_o      = awid_r;
    assign AWADDR_o    = awaddr_r;
    assign AWLEN_o     = awlen_r;
    assign AWSIZE_o    = awsize_r;
    assign AWBURST_o   = awburst_r;
    assign AWVALID_o   = awvalid_r;
    assign WVALID_o    = wvalid_s;
    assign WLAST_o     = wlast_s;
    assign WDATA_o     = (wr_state_r == WR_DATA) ? w_sel_s[36:5] : 32'd0;
    assign WSTRB_o     = (wr_state_r == WR_DATA) ? w_sel_s[4:1] : 4'd0;
    assign BREADY_o    = bready_s;

endmodule
